// File: rtl/bus_timer_irq.sv
// bus_timer_irq: memory-mapped 16-bit down-counting timer with prescaler, auto-reload and level irq.
module bus_timer_irq #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int PRESC_W = 16
) (
  input  logic        clk_bus,
  input  logic        rst_bus,
  input  logic [15:0] bus_addr,
  input  logic [15:0] bus_wdata,
  input  logic        bus_write,
  output logic [15:0] bus_rdata,
  output logic        sel,
  output logic        irq
);
  logic en, ar, ie, flag;
  logic [PRESC_W-1:0] presc, pcnt;
  logic [15:0] reload, count, off, presc_rd;
  logic wr, wr_ctrl, wr_presc, wr_reload, wr_count, wr_status, tick, tick_act, expire;
  always_comb begin
    off = bus_addr - BASE_ADDR;
    sel = off < 16'd5;
    wr = bus_write & sel;
    wr_ctrl = wr & (off == 16'd0);
    wr_presc = wr & (off == 16'd1);
    wr_reload = wr & (off == 16'd2);
    wr_count = wr & (off == 16'd3);
    wr_status = wr & (off == 16'd4);
    tick = en & (pcnt == presc);
    // a COUNT write or a disabling CTRL write in the tick cycle suppresses that tick
    tick_act = tick & ~wr_count & ~(wr_ctrl & ~bus_wdata[0]);
    expire = tick_act & (count == 16'd0);
    presc_rd = '0;
    presc_rd[PRESC_W-1:0] = presc;
    bus_rdata = !sel ? 16'd0 :
                off == 16'd0 ? {13'd0, ie, ar, en} :
                off == 16'd1 ? presc_rd :
                off == 16'd2 ? reload :
                off == 16'd3 ? count : {15'd0, flag};
  end
  always_ff @(posedge clk_bus) begin
    if (rst_bus) begin
      en <= 1'b0;
      ar <= 1'b0;
      ie <= 1'b0;
      flag <= 1'b0;
      presc <= '0;
      pcnt <= '0;
      reload <= '0;
      count <= '0;
      irq <= 1'b0;
    end else begin
      en <= wr_ctrl ? bus_wdata[0] : (expire & ~ar) ? 1'b0 : en;
      ar <= wr_ctrl ? bus_wdata[1] : ar;
      ie <= wr_ctrl ? bus_wdata[2] : ie;
      presc <= wr_presc ? bus_wdata[PRESC_W-1:0] : presc;
      reload <= wr_reload ? bus_wdata : reload;
      count <= wr_count ? bus_wdata :
               !tick_act ? count :
               count != 16'd0 ? count - 16'd1 :
               ar ? reload : count;
      // expiry set beats a same-cycle W1C
      flag <= expire | (flag & ~(wr_status & bus_wdata[0]));
      pcnt <= (wr_ctrl | wr_count | ~en | tick) ? '0 : pcnt + PRESC_W'(1);
      irq <= flag & ie;
    end
  end
endmodule

// File: tb/tb_bus_timer_irq.sv
// tb_bus_timer_irq: table-driven register/decode vectors plus directed timing sequences.
module tb_bus_timer_irq;
  logic clk_bus = 1'b0;
  logic rst_bus = 1'b1;
  logic [15:0] bus_addr = 16'h0000;
  logic [15:0] bus_wdata = 16'h0000;
  logic bus_write = 1'b0;
  logic [15:0] bus_rdata;
  logic sel, irq;
  int n_pass = 0;
  int n_total = 0;

  localparam logic [15:0] CTRL = 16'hFF00, PRESC = 16'hFF01, RELOAD = 16'hFF02, COUNT = 16'hFF03, STATUS = 16'hFF04;

  typedef struct {
    logic wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic exp_sel;
  } vec_t;
  vec_t vt[14];

  bus_timer_irq dut (
    .clk_bus(clk_bus), .rst_bus(rst_bus), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_write(bus_write), .bus_rdata(bus_rdata), .sel(sel), .irq(irq)
  );

  always #5 clk_bus = ~clk_bus;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] a, input logic [15:0] exp);
    bus_addr = a;
    #1;
    chk(nm, bus_rdata, exp);
  endtask

  task automatic irq_chk(input string nm, input logic exp);
    chk(nm, {15'd0, irq}, {15'd0, exp});
  endtask

  task automatic wr_bus(input logic [15:0] a, input logic [15:0] d);
    bus_addr = a;
    bus_wdata = d;
    bus_write = 1'b1;
    @(negedge clk_bus);
    bus_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_bus);
  endtask

  initial begin
    vt[0]  = '{1'b1, CTRL,     16'hFFF8, 16'h0000, 1'b1};
    vt[1]  = '{1'b1, PRESC,    16'h1234, 16'h1234, 1'b1};
    vt[2]  = '{1'b1, RELOAD,   16'hBEEF, 16'hBEEF, 1'b1};
    vt[3]  = '{1'b1, COUNT,    16'h00A5, 16'h00A5, 1'b1};
    vt[4]  = '{1'b1, STATUS,   16'hFFFF, 16'h0000, 1'b1};
    vt[5]  = '{1'b1, 16'hFF05, 16'hFFFF, 16'h0000, 1'b0};
    vt[6]  = '{1'b1, 16'hFEFF, 16'hFFFF, 16'h0000, 1'b0};
    vt[7]  = '{1'b0, RELOAD,   16'h0000, 16'hBEEF, 1'b1};
    vt[8]  = '{1'b0, COUNT,    16'h0000, 16'h00A5, 1'b1};
    vt[9]  = '{1'b0, PRESC,    16'h0000, 16'h1234, 1'b1};
    vt[10] = '{1'b1, CTRL,     16'h0006, 16'h0006, 1'b1};
    vt[11] = '{1'b1, CTRL,     16'h0000, 16'h0000, 1'b1};
    vt[12] = '{1'b1, PRESC,    16'h0000, 16'h0000, 1'b1};
    vt[13] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};

    idle(3);
    rst_bus = 1'b0;
    for (int i = 0; i < 5; i++) rd_chk($sformatf("rst_reg%0d", i), CTRL + 16'(i), 16'h0000);
    irq_chk("rst_irq", 1'b0);
    bus_addr = 16'h0000;
    #1;
    chk("rst_sel", {15'd0, sel}, 16'h0000);

    for (int i = 0; i < 14; i++) begin
      if (vt[i].wr) wr_bus(vt[i].addr, vt[i].wdata);
      rd_chk($sformatf("vec%0d_rd", i), vt[i].addr, vt[i].exp_rd);
      chk($sformatf("vec%0d_sel", i), {15'd0, sel}, {15'd0, vt[i].exp_sel});
    end

    wr_bus(COUNT, 16'd3);
    wr_bus(CTRL, 16'd5);
    idle(3);
    rd_chk("os_flag_e3", STATUS, 16'd0);
    rd_chk("os_count_e3", COUNT, 16'd0);
    idle(1);
    rd_chk("os_flag_e4", STATUS, 16'd1);
    irq_chk("os_irq_e4", 1'b0);
    idle(1);
    irq_chk("os_irq_e5", 1'b1);
    rd_chk("os_ctrl", CTRL, 16'd4);
    rd_chk("os_count", COUNT, 16'd0);
    wr_bus(STATUS, 16'd1);
    rd_chk("os_flag_clr", STATUS, 16'd0);
    irq_chk("os_irq_hold", 1'b1);
    idle(1);
    irq_chk("os_irq_drop", 1'b0);

    wr_bus(PRESC, 16'd3);
    wr_bus(RELOAD, 16'd1);
    wr_bus(COUNT, 16'd1);
    wr_bus(CTRL, 16'd7);
    rd_chk("ar_count_e0", COUNT, 16'd1);
    idle(3);
    rd_chk("ar_count_e3", COUNT, 16'd1);
    idle(1);
    rd_chk("ar_count_e4", COUNT, 16'd0);
    idle(3);
    rd_chk("ar_flag_e7", STATUS, 16'd0);
    idle(1);
    rd_chk("ar_count_e8", COUNT, 16'd1);
    rd_chk("ar_flag_e8", STATUS, 16'd1);
    idle(1);
    irq_chk("ar_irq_e9", 1'b1);
    rd_chk("ar_ctrl_e9", CTRL, 16'd7);
    idle(3);
    rd_chk("ar_count_e12", COUNT, 16'd0);
    idle(4);
    rd_chk("ar_count_e16", COUNT, 16'd1);
    wr_bus(CTRL, 16'd0);
    wr_bus(STATUS, 16'd1);
    wr_bus(PRESC, 16'd0);
    rd_chk("ar_flag_clr", STATUS, 16'd0);

    wr_bus(COUNT, 16'd0);
    wr_bus(CTRL, 16'd1);
    wr_bus(STATUS, 16'd1);
    rd_chk("col_w1c_flag", STATUS, 16'd1);
    rd_chk("col_w1c_ctrl", CTRL, 16'd0);
    wr_bus(PRESC, 16'd1);
    wr_bus(COUNT, 16'd20);
    wr_bus(CTRL, 16'd1);
    idle(1);
    rd_chk("col_cnt_pre", COUNT, 16'd20);
    wr_bus(COUNT, 16'd9);
    rd_chk("col_cnt_wr", COUNT, 16'd9);
    idle(1);
    rd_chk("col_cnt_hold", COUNT, 16'd9);
    idle(1);
    rd_chk("col_cnt_dec", COUNT, 16'd8);
    wr_bus(CTRL, 16'd0);
    wr_bus(PRESC, 16'd0);

    wr_bus(COUNT, 16'd100);
    wr_bus(CTRL, 16'd7);
    idle(3);
    rd_chk("mid_count", COUNT, 16'd97);
    irq_chk("mid_irq", 1'b1);
    rst_bus = 1'b1;
    @(negedge clk_bus);
    rst_bus = 1'b0;
    rd_chk("mid_rst_count", COUNT, 16'd0);
    rd_chk("mid_rst_ctrl", CTRL, 16'd0);
    rd_chk("mid_rst_flag", STATUS, 16'd0);
    irq_chk("mid_rst_irq", 1'b0);
    idle(2);
    rd_chk("mid_rst_idle", COUNT, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
